// File: rtl/n1_sbus_pkg.sv
// Shared types and defaults for the N1 stack bus arbiter.
package n1_sbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } sbus_state_e;

  localparam logic PS = 1'b0;
  localparam logic RS = 1'b1;

  localparam int DEF_SP_WIDTH   = 12;
  localparam int DEF_CELL_WIDTH = 16;
  localparam int DEF_TO_CYCLES  = 255;

  // A disabled timeout (0 cycles) still needs a one-bit counter to stay legal.
  function automatic int to_cnt_width(input int to_cycles);
    return (to_cycles > 0) ? $clog2(to_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/n1_sbus_arb_if.sv
// Pipelined Wishbone stack bus between the arbiter (master) and stack memory (slave).
interface n1_sbus_arb_if #(
  parameter int CELL_WIDTH = 16
);
  // Handshake: the address phase is accepted in any cycle with stb && !stall;
  // the data phase completes in the cycle ack is high while cyc is held.
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [CELL_WIDTH-1:0] dat_w;
  logic [CELL_WIDTH-1:0] dat_r;
  logic                  ack;
  logic                  stall;

  modport master (output cyc, stb, we, dat_w, input dat_r, ack, stall);
  modport slave  (input cyc, stb, we, dat_w, output dat_r, ack, stall);

endinterface

// File: rtl/n1_sbus_rr.sv
// Two-requester round-robin picker; the stack not served last wins a tie.
module n1_sbus_rr
  import n1_sbus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_sel,
  output logic       gnt_vld,
  output logic       gnt_sel
);

  logic last_q;

  // Reset value RS makes PS the favoured stack out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= RS;
    end else if (upd) begin
      last_q <= upd_sel;
    end
  end

  assign gnt_vld = |req;
  assign gnt_sel = (&req) ? ~last_q : req[1];

endmodule

// File: rtl/n1_sbus_arb.sv
// Stack bus arbiter: grants PS/RS spill and fill requests and runs one Wishbone
// transfer at a time, steering the stack AGU so each completed transfer moves one pointer.
module n1_sbus_arb
  import n1_sbus_pkg::*;
#(
  parameter int SP_WIDTH   = DEF_SP_WIDTH,
  parameter int CELL_WIDTH = DEF_CELL_WIDTH,
  parameter int TO_CYCLES  = DEF_TO_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  ps_push_req_i,
  input  logic                  ps_pull_req_i,
  input  logic                  rs_push_req_i,
  input  logic                  rs_pull_req_i,
  input  logic [CELL_WIDTH-1:0] ps_wdat_i,
  input  logic [CELL_WIDTH-1:0] rs_wdat_i,
  output logic                  ps_ack_o,
  output logic                  rs_ack_o,
  output logic [CELL_WIDTH-1:0] rdat_o,
  n1_sbus_arb_if.master         sbus,
  output logic                  arb2sagu_hold_o,
  output logic                  arb2sagu_stack_sel_o,
  output logic                  arb2sagu_push_o,
  output logic                  arb2sagu_pull_o,
  input  logic                  sagu2arb_psof_i,
  input  logic                  sagu2arb_rsof_i,
  input  logic                  sagu2arb_lps_empty_i,
  input  logic                  sagu2arb_lrs_empty_i,
  output logic                  arb2excpt_psuf_o,
  output logic                  arb2excpt_rsuf_o,
  output logic                  arb2excpt_psof_o,
  output logic                  arb2excpt_rsof_o,
  output logic                  arb2excpt_to_o,
  output sbus_state_e           dbg_state_o
);

  localparam int TW = to_cnt_width(TO_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'((TO_CYCLES > 0) ? TO_CYCLES - 1 : 0);

  if (SP_WIDTH < 1 || CELL_WIDTH < 1) begin : g_bad_width
    $error("n1_sbus_arb: SP_WIDTH and CELL_WIDTH must be positive");
  end

  sbus_state_e           state_q;
  logic                  sel_q, dir_q, xfer_q;
  logic                  cyc_q, stb_q, we_q;
  logic [CELL_WIDTH-1:0] dat_q, rdat_q;
  logic [TW-1:0]         to_cnt_q;
  logic                  ps_ack_q, rs_ack_q;
  logic                  psof_q, rsof_q, psuf_q, rsuf_q, to_q;

  logic ps_req, rs_req, gnt_vld, gnt_sel, gnt_push, refuse, done, to_hit;

  // A requester keeps its level up during its ack cycle; masking it there
  // prevents the same request from being granted a second time.
  assign ps_req = (ps_push_req_i | ps_pull_req_i) & ~ps_ack_q;
  assign rs_req = (rs_push_req_i | rs_pull_req_i) & ~rs_ack_q;

  assign gnt_push = (gnt_sel == RS) ? rs_push_req_i : ps_push_req_i;
  assign refuse   = gnt_push ? ((gnt_sel == RS) ? sagu2arb_rsof_i : sagu2arb_psof_i)
                             : ((gnt_sel == RS) ? sagu2arb_lrs_empty_i : sagu2arb_lps_empty_i);
  assign done     = (state_q == DATA) && sbus.ack;
  assign to_hit   = (TO_CYCLES != 0) && (to_cnt_q == TO_LAST);

  n1_sbus_rr u_rr (
    .clk     (clk_i),
    .rst_n   (async_rst_i),
    .req     ({rs_req, ps_req}),
    .upd     (done),
    .upd_sel (sel_q),
    .gnt_vld (gnt_vld),
    .gnt_sel (gnt_sel)
  );

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state_q  <= IDLE;
      sel_q    <= PS;
      dir_q    <= 1'b0;
      xfer_q   <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      dat_q    <= '0;
      rdat_q   <= '0;
      to_cnt_q <= '0;
      ps_ack_q <= 1'b0;
      rs_ack_q <= 1'b0;
      psof_q   <= 1'b0;
      rsof_q   <= 1'b0;
      psuf_q   <= 1'b0;
      rsuf_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      ps_ack_q <= 1'b0;
      rs_ack_q <= 1'b0;
      psof_q   <= 1'b0;
      rsof_q   <= 1'b0;
      psuf_q   <= 1'b0;
      rsuf_q   <= 1'b0;
      to_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          xfer_q <= 1'b0;
          if (gnt_vld && refuse) begin
            // Overflowing push or underflowing pull: answer at once, no bus cycle.
            ps_ack_q <= (gnt_sel == PS);
            rs_ack_q <= (gnt_sel == RS);
            psof_q   <= (gnt_sel == PS) &  gnt_push;
            psuf_q   <= (gnt_sel == PS) & ~gnt_push;
            rsof_q   <= (gnt_sel == RS) &  gnt_push;
            rsuf_q   <= (gnt_sel == RS) & ~gnt_push;
          end else if (gnt_vld) begin
            sel_q    <= gnt_sel;
            dir_q    <= gnt_push;
            xfer_q   <= 1'b1;
            cyc_q    <= 1'b1;
            stb_q    <= 1'b1;
            we_q     <= gnt_push;
            dat_q    <= (gnt_sel == RS) ? rs_wdat_i : ps_wdat_i;
            to_cnt_q <= '0;
            state_q  <= ADDR;
          end
        end
        ADDR: begin
          to_cnt_q <= to_cnt_q + TW'(1);
          if (to_hit) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            to_q    <= 1'b1;
            state_q <= IDLE;
          end else if (!sbus.stall) begin
            stb_q   <= 1'b0;
            state_q <= DATA;
          end
        end
        DATA: begin
          to_cnt_q <= to_cnt_q + TW'(1);
          if (sbus.ack) begin
            cyc_q    <= 1'b0;
            rdat_q   <= sbus.dat_r;
            ps_ack_q <= (sel_q == PS);
            rs_ack_q <= (sel_q == RS);
            state_q  <= IDLE;
          end else if (to_hit) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            to_q    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sbus.cyc   = cyc_q;
  assign sbus.stb   = stb_q;
  assign sbus.we    = we_q;
  assign sbus.dat_w = dat_q;

  // Hold drops combinationally in the ack cycle so the AGU commits with the transfer.
  assign arb2sagu_hold_o      = ~done;
  assign arb2sagu_stack_sel_o = sel_q;
  assign arb2sagu_push_o      = xfer_q &  dir_q;
  assign arb2sagu_pull_o      = xfer_q & ~dir_q;

  assign ps_ack_o         = ps_ack_q;
  assign rs_ack_o         = rs_ack_q;
  assign rdat_o           = rdat_q;
  assign arb2excpt_psof_o = psof_q;
  assign arb2excpt_rsof_o = rsof_q;
  assign arb2excpt_psuf_o = psuf_q;
  assign arb2excpt_rsuf_o = rsuf_q;
  assign arb2excpt_to_o   = to_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_n1_sbus_arb.sv
// Directed bench for n1_sbus_arb: bus slave model, ack scoreboard, timeout instance.
module tb_n1_sbus_arb;
  import n1_sbus_pkg::*;

  localparam int W  = 16;
  localparam int QW = W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main DUT signals
  logic ps_push = 0, ps_pull = 0, rs_push = 0, rs_pull = 0;
  logic [W-1:0] ps_wdat = '0, rs_wdat = '0;
  logic psof_i = 0, rsof_i = 0, lps_empty = 0, lrs_empty = 0;
  logic ps_ack, rs_ack, hold, ssel, spush, spull;
  logic psuf_o, rsuf_o, psof_o, rsof_o, to_o;
  logic [W-1:0] rdat;
  sbus_state_e state;
  n1_sbus_arb_if #(.CELL_WIDTH(W)) bus ();

  // timeout DUT signals
  logic t_ps_push = 0;
  logic t_ps_ack, t_rs_ack, t_hold, t_ssel, t_spush, t_spull;
  logic t_psuf, t_rsuf, t_psof, t_rsof, t_to;
  logic [W-1:0] t_rdat;
  sbus_state_e t_state;
  n1_sbus_arb_if #(.CELL_WIDTH(W)) tbus ();

  n1_sbus_arb #(.SP_WIDTH(12), .CELL_WIDTH(W), .TO_CYCLES(255)) dut (
    .clk_i(clk), .async_rst_i(rst_n),
    .ps_push_req_i(ps_push), .ps_pull_req_i(ps_pull),
    .rs_push_req_i(rs_push), .rs_pull_req_i(rs_pull),
    .ps_wdat_i(ps_wdat), .rs_wdat_i(rs_wdat),
    .ps_ack_o(ps_ack), .rs_ack_o(rs_ack), .rdat_o(rdat),
    .sbus(bus),
    .arb2sagu_hold_o(hold), .arb2sagu_stack_sel_o(ssel),
    .arb2sagu_push_o(spush), .arb2sagu_pull_o(spull),
    .sagu2arb_psof_i(psof_i), .sagu2arb_rsof_i(rsof_i),
    .sagu2arb_lps_empty_i(lps_empty), .sagu2arb_lrs_empty_i(lrs_empty),
    .arb2excpt_psuf_o(psuf_o), .arb2excpt_rsuf_o(rsuf_o),
    .arb2excpt_psof_o(psof_o), .arb2excpt_rsof_o(rsof_o),
    .arb2excpt_to_o(to_o), .dbg_state_o(state)
  );

  n1_sbus_arb #(.SP_WIDTH(12), .CELL_WIDTH(W), .TO_CYCLES(4)) dut_to (
    .clk_i(clk), .async_rst_i(rst_n),
    .ps_push_req_i(t_ps_push), .ps_pull_req_i(1'b0),
    .rs_push_req_i(1'b0), .rs_pull_req_i(1'b0),
    .ps_wdat_i(16'h7777), .rs_wdat_i(16'h0000),
    .ps_ack_o(t_ps_ack), .rs_ack_o(t_rs_ack), .rdat_o(t_rdat),
    .sbus(tbus),
    .arb2sagu_hold_o(t_hold), .arb2sagu_stack_sel_o(t_ssel),
    .arb2sagu_push_o(t_spush), .arb2sagu_pull_o(t_spull),
    .sagu2arb_psof_i(1'b0), .sagu2arb_rsof_i(1'b0),
    .sagu2arb_lps_empty_i(1'b0), .sagu2arb_lrs_empty_i(1'b0),
    .arb2excpt_psuf_o(t_psuf), .arb2excpt_rsuf_o(t_rsuf),
    .arb2excpt_psof_o(t_psof), .arb2excpt_rsof_o(t_rsof),
    .arb2excpt_to_o(t_to), .dbg_state_o(t_state)
  );

  initial begin
    tbus.stall = 1'b0;
    tbus.ack   = 1'b0;
    tbus.dat_r = '0;
  end

  // ---------------- bus slave model ----------------
  int stall_n = 0;
  int wait_n  = 0;
  logic [W-1:0] s_rdata = '0;
  bit in_addr = 0, pend = 0;
  int scnt = 0, wcnt = 0;

  initial begin
    bus.stall = 1'b0;
    bus.ack   = 1'b0;
    bus.dat_r = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.ack   = 1'b0;
      bus.stall = 1'b0;
      if (!bus.cyc) begin
        in_addr = 0;
        pend    = 0;
      end else if (bus.stb) begin
        if (!in_addr) begin
          in_addr = 1;
          scnt    = stall_n;
        end
        if (scnt > 0) begin
          bus.stall = 1'b1;
          scnt--;
        end else begin
          in_addr = 0;
          pend    = 1;
          wcnt    = wait_n;
        end
      end else if (pend) begin
        if (wcnt > 0) wcnt--;
        else begin
          bus.ack   = 1'b1;
          bus.dat_r = s_rdata;
          pend      = 0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard entry: {stack, check_rdat, rdat}
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] e;

  always @(negedge clk) begin
    if (rst_n && (ps_ack || rs_ack)) begin
      check("ack_expected", (exp_q.size() != 0), 1'b1);
      check("ack_onehot", ps_ack ^ rs_ack, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ack_stack", rs_ack, e[QW-1]);
        if (e[W]) check("rdat", rdat, e[W-1:0]);
      end
    end
  end

  int t_acks = 0;
  always @(negedge clk) if (t_ps_ack || t_rs_ack) t_acks++;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  logic bench_last;
  logic nxt;
  int ps_n, rs_n, guard;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hold", hold, 1'b1);
    check("rst_cyc", bus.cyc, 1'b0);
    check("rst_stb", bus.stb, 1'b0);
    check("rst_we", bus.we, 1'b0);
    check("rst_acks", {ps_ack, rs_ack, spush, spull, ssel}, 5'b0);
    check("rst_excpt", {psuf_o, rsuf_o, psof_o, rsof_o, to_o}, 5'b0);
    check("rst_state", state, IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // PS push, no stall
    ps_wdat = 16'hA5A5;
    ps_push = 1'b1;
    exp_q.push_back({PS, 1'b0, 16'h0});
    check("p1_c0_cyc", bus.cyc, 1'b0);
    @(negedge clk);
    check("p1_c1_cyc_stb_we", {bus.cyc, bus.stb, bus.we}, 3'b111);
    check("p1_c1_dat", bus.dat_w, 16'hA5A5);
    check("p1_c1_agu", {hold, ssel, spush, spull}, 4'b1010);
    @(negedge clk);
    check("p1_c2_cyc_stb", {bus.cyc, bus.stb}, 2'b10);
    check("p1_c2_hold", hold, 1'b0);
    check("p1_c2_ack", ps_ack, 1'b0);
    @(negedge clk);
    check("p1_c3_ack", ps_ack, 1'b1);
    check("p1_c3_hold", hold, 1'b1);
    check("p1_c3_cyc", bus.cyc, 1'b0);
    check("p1_c3_push_stable", spush, 1'b1);
    ps_push = 1'b0;
    @(negedge clk);
    check("p1_c4_idle", {ps_ack, spush, bus.cyc}, 3'b000);
    bench_last = PS;

    // RS pull with 2 stall cycles and 3 wait cycles
    stall_n = 2;
    wait_n  = 3;
    s_rdata = 16'hBEEF;
    rs_pull = 1'b1;
    exp_q.push_back({RS, 1'b1, 16'hBEEF});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("st_stb", {bus.cyc, bus.stb, bus.we}, 3'b110);
      check("st_agu", {hold, ssel, spull}, 3'b111);
    end
    for (int c = 4; c <= 6; c++) begin
      @(negedge clk);
      check("st_wait", {bus.cyc, bus.stb, hold}, 3'b101);
    end
    @(negedge clk);
    check("st_c7_hold", hold, 1'b0);
    check("st_c7_ack", rs_ack, 1'b0);
    @(negedge clk);
    check("st_c8_ack", rs_ack, 1'b1);
    check("st_c8_pull_stable", {ssel, spull}, 2'b11);
    rs_pull = 1'b0;
    stall_n = 0;
    wait_n  = 0;
    bench_last = RS;
    @(negedge clk);

    // RS pull on empty lower stack
    lrs_empty = 1'b1;
    rs_pull   = 1'b1;
    exp_q.push_back({RS, 1'b0, 16'h0});
    @(negedge clk);
    check("uf_ack_strobe", {rs_ack, rsuf_o, psuf_o}, 3'b110);
    check("uf_no_bus", {bus.cyc, hold, spull}, 3'b010);
    rs_pull   = 1'b0;
    lrs_empty = 1'b0;
    @(negedge clk);
    check("uf_after", {rs_ack, rsuf_o, bus.cyc}, 3'b000);

    // PS push on overflow
    psof_i  = 1'b1;
    ps_push = 1'b1;
    exp_q.push_back({PS, 1'b0, 16'h0});
    @(negedge clk);
    check("of_ack_strobe", {ps_ack, psof_o, rsof_o}, 3'b110);
    check("of_no_bus", {bus.cyc, hold, spush}, 3'b010);
    ps_push = 1'b0;
    psof_i  = 1'b0;
    @(negedge clk);

    // simultaneous PS pull and RS push: alternate, starting with the stack not served last
    s_rdata = 16'h1234;
    rs_wdat = 16'h5A5A;
    nxt = ~bench_last;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({nxt, (nxt == PS), (nxt == PS) ? 16'h1234 : 16'h0000});
      nxt = ~nxt;
    end
    ps_pull = 1'b1;
    rs_push = 1'b1;
    ps_n = 0;
    rs_n = 0;
    guard = 0;
    while ((ps_n + rs_n) < 10 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (bus.stb && bus.we) check("rr_wdat", bus.dat_w, 16'h5A5A);
      if (ps_ack) begin
        ps_n++;
        if (ps_n == 5) ps_pull = 1'b0;
      end
      if (rs_ack) begin
        rs_n++;
        if (rs_n == 5) rs_push = 1'b0;
      end
    end
    ps_pull = 1'b0;
    rs_push = 1'b0;
    check("rr_total", ps_n + rs_n, 10);
    check("rr_ps_share", ps_n, 5);
    check("rr_rs_share", rs_n, 5);
    repeat (4) @(negedge clk);
    check("rr_quiet", bus.cyc, 1'b0);

    // async reset in the data phase
    wait_n  = 50;
    ps_wdat = 16'h1111;
    ps_push = 1'b1;
    repeat (2) @(negedge clk);
    check("rm_in_data", {bus.cyc, bus.stb}, 2'b10);
    check("rm_state", state, DATA);
    #1 rst_n = 1'b0;
    #1;
    check("rm_bus_drop", {bus.cyc, bus.stb, bus.we}, 3'b000);
    check("rm_hold", hold, 1'b1);
    check("rm_agu", {spush, spull}, 2'b00);
    ps_push = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    wait_n = 0;
    @(negedge clk);
    check("rm_idle", state, IDLE);
    check("rm_idle_bus", {bus.cyc, hold}, 2'b01);

    // bus timeout on the TO_CYCLES=4 instance
    t_ps_push = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("to_cyc_high", t_cyc_val(), 1'b1);
      check("to_no_strobe", t_to, 1'b0);
    end
    @(negedge clk);
    check("to_strobe", t_to, 1'b1);
    check("to_cyc_low", {tbus.cyc, tbus.stb}, 2'b00);
    check("to_hold", t_hold, 1'b1);
    check("to_no_ack", t_ps_ack, 1'b0);
    @(negedge clk);
    check("to_retry", {tbus.cyc, tbus.stb, t_to}, 3'b110);
    t_ps_push = 1'b0;
    repeat (8) @(negedge clk);
    check("to_quiet", tbus.cyc, 1'b0);
    check("to_never_acked", t_acks, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic t_cyc_val();
    return tbus.cyc;
  endfunction

endmodule
